// File: rtl/mvm_out_collector_if.sv
// Handshake bundle between the vector-matrix multiply output stage and its consumer.
// The slave modport is the collector's view. The master modport is the driver/consumer view.
interface mvm_out_collector_if #(
    parameter int DW     = 8,
    parameter int TOUT   = 8,
    parameter int H_W    = 10,
    parameter int T_W    = 8,
    parameter int ADDR_W = 18
);
    localparam int WW = DW * TOUT;

    logic              start;
    logic [H_W-1:0]    height;
    logic [T_W-1:0]    wout_tiles;
    logic              in_vld;
    logic [WW-1:0]     in_dat;
    logic              out_vld;
    logic              out_rdy;
    logic [WW-1:0]     out_dat;
    logic [ADDR_W-1:0] out_addr;
    logic              out_last;
    logic              almost_full;
    logic              busy;
    logic              done;
    logic              err;

    modport slave (
        input  start, height, wout_tiles, in_vld, in_dat, out_rdy,
        output out_vld, out_dat, out_addr, out_last, almost_full, busy, done, err
    );

    modport master (
        output start, height, wout_tiles, in_vld, in_dat, out_rdy,
        input  out_vld, out_dat, out_addr, out_last, almost_full, busy, done, err
    );
endinterface

// File: rtl/mvm_out_collector.sv
// Output collector for the vector-matrix multiply top.
// The stage absorbs a result stream that cannot be stalled into a small FIFO and drains it over
// valid/ready, with the word address and an end-of-layer flag. It raises almost_full so that
// upstream can throttle, and it flags a sticky error whenever a word has to be dropped.
module mvm_out_collector #(
    parameter int DW        = 8,
    parameter int TOUT      = 8,
    parameter int DEPTH     = 16,
    parameter int AF_MARGIN = 4,
    parameter int H_W       = 10,
    parameter int T_W       = 8,
    parameter int ADDR_W    = 18
) (
    input  logic                clk,
    input  logic                rst_n,
    mvm_out_collector_if.slave  bus
);
    localparam int WW = DW * TOUT;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = H_W + T_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;

    logic [WW-1:0]   mem_r [DEPTH];
    logic [AW-1:0]   wptr_r;
    logic [AW-1:0]   rptr_r;
    logic [CW-1:0]   count_r;
    logic [TW-1:0]   in_cnt_r;
    logic [TW-1:0]   out_cnt_r;
    logic [TW-1:0]   total_r;
    logic            err_r;

    logic [TW-1:0]   total_new_s;
    logic            vld_s;
    logic            pop_s;
    logic            push_s;
    logic            drop_s;
    logic            head_last_s;
    logic [CW-1:0]   free_s;

    // The layer size is computed at full width so that the largest height*tiles cannot wrap.
    assign total_new_s = TW'(bus.height) * TW'(bus.wout_tiles);

    assign vld_s  = (count_r != CW'(0));
    assign pop_s  = vld_s && bus.out_rdy;

    // A start cycle only flushes, so a word arriving with it is discarded without an error.
    // A full FIFO can still take a word when the head leaves in the same cycle.
    assign push_s = bus.in_vld && !bus.start && (state_r == ST_RUN) &&
                    (in_cnt_r < total_r) && ((count_r != CW'(DEPTH)) || pop_s);
    assign drop_s = bus.in_vld && !bus.start && !push_s;

    // out_cnt is always below total while a word is buffered, so the +1 form cannot underflow.
    assign head_last_s = vld_s && ((out_cnt_r + TW'(1)) == total_r);

    assign free_s = CW'(DEPTH) - count_r;

    assign bus.out_vld     = vld_s;
    assign bus.out_dat     = mem_r[rptr_r];
    assign bus.out_addr    = ADDR_W'(out_cnt_r);
    assign bus.out_last    = head_last_s;
    assign bus.almost_full = (free_s <= CW'(AF_MARGIN));
    assign bus.busy        = (state_r == ST_RUN);
    assign bus.done        = (state_r == ST_DONE);
    assign bus.err         = err_r;

    // Layer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic. start overrides everything. DONE lasts exactly one cycle.
    always_comb begin
        state_nxt_s = state_r;
        if (bus.start) begin
            if (total_new_s == TW'(0)) begin
                state_nxt_s = ST_DONE;
            end else begin
                state_nxt_s = ST_RUN;
            end
        end else begin
            case (state_r)
                ST_IDLE: state_nxt_s = ST_IDLE;
                ST_RUN: begin
                    if (pop_s && head_last_s) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_DONE: state_nxt_s = ST_IDLE;
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // FIFO pointers, occupancy, layer counters and the sticky drop flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_r    <= AW'(0);
            rptr_r    <= AW'(0);
            count_r   <= CW'(0);
            in_cnt_r  <= TW'(0);
            out_cnt_r <= TW'(0);
            total_r   <= TW'(0);
            err_r     <= 1'b0;
        end else if (bus.start) begin
            wptr_r    <= AW'(0);
            rptr_r    <= AW'(0);
            count_r   <= CW'(0);
            in_cnt_r  <= TW'(0);
            out_cnt_r <= TW'(0);
            total_r   <= total_new_s;
            err_r     <= 1'b0;
        end else begin
            if (push_s) begin
                wptr_r   <= wptr_r + AW'(1);
                in_cnt_r <= in_cnt_r + TW'(1);
            end
            if (pop_s) begin
                rptr_r    <= rptr_r + AW'(1);
                out_cnt_r <= out_cnt_r + TW'(1);
            end
            if (push_s && !pop_s) begin
                count_r <= count_r + CW'(1);
            end else if (pop_s && !push_s) begin
                count_r <= count_r - CW'(1);
            end
            if (drop_s) begin
                err_r <= 1'b1;
            end
        end
    end

    // Storage array. It is cleared on reset so that the head data reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WW{1'b0}};
            end
        end else if (push_s) begin
            mem_r[wptr_r] <= bus.in_dat;
        end
    end
endmodule
